// File: rtl/logic2048_pkg.sv
// Shared types and constants for the 2048 board engine.
package logic2048_pkg;

  localparam int unsigned TILE_W   = 4;
  localparam int unsigned WIN_TILE = 11;
  localparam int unsigned N_CELLS  = 16;
  localparam int unsigned N_LINES  = 4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LINE0,
    S_LINE1,
    S_LINE2,
    S_LINE3,
    S_SPAWN,
    S_DONE
  } state_e;

  // Cell index (4r+c) of position pos in the selected line, pos 0 at the wall the tiles move toward.
  function automatic logic [3:0] cell_idx(input dir_e dir, input logic [1:0] line,
                                          input logic [1:0] pos);
    logic [1:0] r;
    logic [1:0] c;
    case (dir)
      UP:      begin r = pos;  c = line; end
      DOWN:    begin r = ~pos; c = line; end
      LEFT:    begin r = line; c = pos;  end
      default: begin r = line; c = ~pos; end
    endcase
    return {r, c};
  endfunction

endpackage

// File: rtl/logic2048_board_mover_line.sv
// Combinational single-line merge: slide toward x0, merge equal pairs once, 15 saturates.
module logic2048SingleLine
  import logic2048_pkg::*;
(
  input  logic [TILE_W-1:0] x0,
  input  logic [TILE_W-1:0] x1,
  input  logic [TILE_W-1:0] x2,
  input  logic [TILE_W-1:0] x3,
  output logic [TILE_W-1:0] y0,
  output logic [TILE_W-1:0] y1,
  output logic [TILE_W-1:0] y2,
  output logic [TILE_W-1:0] y3
);

  logic [TILE_W-1:0] xs  [4];
  logic [TILE_W-1:0] cmp [5];
  logic [TILE_W-1:0] ys  [4];
  logic [2:0]        n;
  logic [2:0]        m;
  logic              skip;

  // Compress nonzero tiles toward x0, then merge pairs scanning from x0.
  // cmp has a fifth, always-empty slot so the pair lookahead never leaves the array.
  always_comb begin
    xs[0] = x0;
    xs[1] = x1;
    xs[2] = x2;
    xs[3] = x3;
    cmp   = '{default: '0};
    n     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (xs[i[1:0]] != '0) begin
        cmp[n] = xs[i[1:0]];
        n      = n + 3'd1;
      end
    end
    ys   = '{default: '0};
    m    = '0;
    skip = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[i[2:0]] != '0) begin
        if (cmp[i[2:0]] == cmp[i[2:0] + 3'd1] && cmp[i[2:0]] != '1) begin
          ys[m[1:0]] = cmp[i[2:0]] + 1'b1;
          skip       = 1'b1;
        end else begin
          ys[m[1:0]] = cmp[i[2:0]];
        end
        m = m + 3'd1;
      end
    end
    y0 = ys[0];
    y1 = ys[1];
    y2 = ys[2];
    y3 = ys[3];
  end

endmodule

// File: rtl/logic2048_board_mover.sv
// 4x4 board engine: sweeps four lines through one shared merger, then spawns tiles.
module logic2048_board_mover
  import logic2048_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_dir,
  output logic        cmd_ready,
  output logic [63:0] board,
  output logic        busy,
  output logic        done,
  output logic        moved,
  output logic        won
);

  state_e            state;
  state_e            line_next;
  dir_e              dir_q;
  logic [63:0]       board_q;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic              changed;
  logic              changed_next;
  logic [1:0]        spawn_cnt;
  logic [3:0]        p;
  logic              won_q;
  logic              any_win;
  logic [1:0]        line_sel;
  logic [3:0]        line_idx [4];
  logic [TILE_W-1:0] x_line   [4];
  logic [TILE_W-1:0] y_line   [4];
  logic [TILE_W-1:0] cell_p;
  logic [TILE_W-1:0] spawn_val;

  // Which line the current LINE state handles and where the sweep goes next.
  always_comb begin
    line_sel  = 2'd0;
    line_next = S_LINE1;
    case (state)
      S_LINE1: begin line_sel = 2'd1; line_next = S_LINE2; end
      S_LINE2: begin line_sel = 2'd2; line_next = S_LINE3; end
      S_LINE3: begin line_sel = 2'd3; line_next = S_DONE;  end
      default: ;
    endcase
  end

  // Extract the selected line, oriented so x0 sits at the destination wall.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      line_idx[k[1:0]] = cell_idx(dir_q, line_sel, k[1:0]);
      x_line[k[1:0]]   = board_q[{line_idx[k[1:0]], 2'b00} +: TILE_W];
    end
  end

  logic2048SingleLine u_line (
    .x0 (x_line[0]),
    .x1 (x_line[1]),
    .x2 (x_line[2]),
    .x3 (x_line[3]),
    .y0 (y_line[0]),
    .y1 (y_line[1]),
    .y2 (y_line[2]),
    .y3 (y_line[3])
  );

  // Change detection, win detection, spawn probe and LFSR step.
  always_comb begin
    changed_next = changed |
                   ({x_line[0], x_line[1], x_line[2], x_line[3]} !=
                    {y_line[0], y_line[1], y_line[2], y_line[3]});
    any_win = 1'b0;
    for (int unsigned c = 0; c < N_CELLS; c++) begin
      if (board_q[{c[3:0], 2'b00} +: TILE_W] >= TILE_W'(WIN_TILE)) any_win = 1'b1;
    end
    cell_p    = board_q[{p, 2'b00} +: TILE_W];
    spawn_val = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // Control FSM with board, LFSR and sticky win flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dir_q     <= UP;
      board_q   <= '0;
      lfsr      <= SEED;
      changed   <= 1'b0;
      spawn_cnt <= '0;
      p         <= '0;
      won_q     <= 1'b0;
    end else begin
      lfsr  <= lfsr_next;
      won_q <= won_q | any_win;
      case (state)
        S_IDLE: begin
          if (start) begin
            board_q   <= '0;
            spawn_cnt <= 2'd2;
            changed   <= 1'b0;
            p         <= lfsr[3:0];
            won_q     <= 1'b0;
            state     <= S_SPAWN;
          end else if (cmd_valid) begin
            dir_q   <= dir_e'(cmd_dir);
            changed <= 1'b0;
            state   <= S_LINE0;
          end
        end
        S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
          for (int unsigned k = 0; k < 4; k++) begin
            board_q[{line_idx[k[1:0]], 2'b00} +: TILE_W] <= y_line[k[1:0]];
          end
          changed <= changed_next;
          if (state == S_LINE3 && changed_next) begin
            spawn_cnt <= 2'd1;
            p         <= lfsr[3:0];
            state     <= S_SPAWN;
          end else begin
            state <= line_next;
          end
        end
        S_SPAWN: begin
          if (cell_p == '0) begin
            board_q[{p, 2'b00} +: TILE_W] <= spawn_val;
            spawn_cnt <= spawn_cnt - 2'd1;
            if (spawn_cnt == 2'd1) state <= S_DONE;
            else p <= lfsr[3:0];
          end else begin
            p <= p + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign board     = board_q;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign moved     = (state == S_DONE) & changed;
  assign won       = won_q;

endmodule
